// File: rtl/mcu32x_mem_pkg.sv
// rtl/mcu32x_mem_pkg.sv - shared types and widths for the data-memory responder
package mcu32x_mem_pkg;
  localparam int MEM_WORD_W = 32;
  localparam int MEM_BE_W   = 4;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;
endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word RAM with byte-lane writes and a registered read port
module dmem_array
  import mcu32x_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic                  we,
  input  logic [MEM_BE_W-1:0]   be,
  input  logic [MEM_WORD_W-1:0] wdata,
  input  logic                  re,
  output logic [MEM_WORD_W-1:0] rdata
);
  logic [MEM_WORD_W-1:0] mem [2**DEPTH_LOG2];
  logic [MEM_WORD_W-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < MEM_BE_W; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read register holds the last completed load; it is reset, the storage is not.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated data-memory responder with one-cycle ready pulse
// Optional DMEM_BOUNDS_CHECK_EN rejects misaligned and out-of-range addresses.
module dmem_responder
  import mcu32x_mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           address,
  input  logic [MEM_WORD_W-1:0] write_data,
  input  logic [MEM_BE_W-1:0]   byte_en,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic [MEM_WORD_W-1:0] read_data,
  output logic                  ready,
  output logic                  error
);
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
    WAIT_CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  dmem_state_e           state_d, state_q;
  logic [WAIT_CNT_W-1:0] cnt_d, cnt_q;
  logic [31:0]           addr_d, addr_q;
  logic [MEM_WORD_W-1:0] wdata_d, wdata_q;
  logic [MEM_BE_W-1:0]   be_d, be_q;
  logic                  rd_d, rd_q, wr_d, wr_q;
  logic                  ready_d, ready_q, error_d, error_q;

  logic [31:0]           cur_addr;
  logic [MEM_WORD_W-1:0] cur_wdata;
  logic [MEM_BE_W-1:0]   cur_be;
  logic                  cur_rd, cur_wr, commit, bad_addr, err_now;

  // With zero wait states the access commits on the sampling edge, so the live inputs feed the RAM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    commit  = 1'b0;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_be    = be_q;
    cur_rd    = rd_q;
    cur_wr    = wr_q;
    case (state_q)
      ST_IDLE: begin
        cur_addr  = address;
        cur_wdata = write_data;
        cur_be    = byte_en;
        cur_rd    = mem_read;
        cur_wr    = mem_write;
        if (mem_read || mem_write) begin
          addr_d  = address;
          wdata_d = write_data;
          be_d    = byte_en;
          rd_d    = mem_read;
          wr_d    = mem_write;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef DMEM_BOUNDS_CHECK_EN
  assign bad_addr = (|cur_addr[1:0]) || (|cur_addr[31:DEPTH_LOG2+2]);
`else
  logic addr_unused;
  assign addr_unused = ^{cur_addr[31:DEPTH_LOG2+2], cur_addr[1:0]};
  assign bad_addr    = 1'b0;
`endif

  assign err_now = (cur_rd && cur_wr) || bad_addr;
  assign ready_d = commit;
  assign error_d = commit && err_now;

  dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .rst   (reset),
    .addr  (cur_addr[DEPTH_LOG2+1:2]),
    .we    (commit && cur_wr && !err_now),
    .be    (cur_be),
    .wdata (cur_wdata),
    .re    (commit && cur_rd && !err_now),
    .rdata (read_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  assign ready = ready_q;
  assign error = error_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized bench for dmem_responder at 0, 1 and 3 wait states
module tb_dmem_responder;
  localparam int WC [3] = '{0, 1, 3};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr_s  [3];
  logic [31:0] wdata_s [3];
  logic [3:0]  be_s    [3];
  logic        rd_s    [3];
  logic        wr_s    [3];
  logic [31:0] rdata_s [3];
  logic        rdy_s   [3];
  logic        err_s   [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_m   [3][1024];
  bit          known_m [3][1024];
  logic [31:0] rd_m    [3];
  bit          rd_ok   [3];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .address(addr_s[0]), .write_data(wdata_s[0]), .byte_en(be_s[0]),
    .mem_read(rd_s[0]), .mem_write(wr_s[0]), .read_data(rdata_s[0]), .ready(rdy_s[0]), .error(err_s[0]));
  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset), .address(addr_s[1]), .write_data(wdata_s[1]), .byte_en(be_s[1]),
    .mem_read(rd_s[1]), .mem_write(wr_s[1]), .read_data(rdata_s[1]), .ready(rdy_s[1]), .error(err_s[1]));
  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset), .address(addr_s[2]), .write_data(wdata_s[2]), .byte_en(be_s[2]),
    .mem_read(rd_s[2]), .mem_write(wr_s[2]), .read_data(rdata_s[2]), .ready(rdy_s[2]), .error(err_s[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit addr_rejected(input logic [31:0] a);
`ifdef DMEM_BOUNDS_CHECK_EN
    return (a % 4 != 0) || (a >= 32'h1000);
`else
    return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
  endfunction

  // Issues one transaction on unit u, then checks latency, error, data and the ready de-assert.
  task automatic run_txn(input int u, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    int  lat;
    int  word;
    bit  exp_err;
    exp_err = (r && w) || addr_rejected(a);
    word    = int'((a / 4) % 1024);
    addr_s[u] = a; wdata_s[u] = d; be_s[u] = be; rd_s[u] = r; wr_s[u] = w;
    lat = -1;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (rdy_s[u]) begin
        lat = e;
        break;
      end
    end
    rd_s[u] = 1'b0; wr_s[u] = 1'b0; addr_s[u] = $urandom; wdata_s[u] = $urandom;
    check_eq("latency", 32'(lat), 32'(WC[u]));
    if (lat < 0) return;
    check_eq("error", {31'd0, err_s[u]}, {31'd0, exp_err});
    if (!exp_err && w) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem_m[u][word][8*i +: 8] = d[8*i +: 8];
      if (be == 4'hF) known_m[u][word] = 1'b1;
    end
    if (!exp_err && r) begin
      rd_m[u]  = mem_m[u][word];
      rd_ok[u] = known_m[u][word];
    end
    if (rd_ok[u]) check_eq("rdata", rdata_s[u], rd_m[u]);
    @(posedge clk); #1;
    check_eq("ready_drop", {31'd0, rdy_s[u]}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int          k;
    for (int u = 0; u < 3; u++) begin
      addr_s[u] = '0; wdata_s[u] = '0; be_s[u] = '0; rd_s[u] = 1'b0; wr_s[u] = 1'b0;
      rd_m[u] = '0; rd_ok[u] = 1'b1;
      for (int i = 0; i < 1024; i++) known_m[u][i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      check_eq("rst_ready", {31'd0, rdy_s[u]}, 32'd0);
      check_eq("rst_error", {31'd0, err_s[u]}, 32'd0);
      check_eq("rst_rdata", rdata_s[u], 32'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    run_txn(1, 0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    run_txn(1, 1, 0, 32'h10, 32'h0, 4'h0);
    run_txn(1, 0, 1, 32'h10, 32'h0000_00AA, 4'h1);
    run_txn(1, 1, 0, 32'h10, 32'h0, 4'h0);
    check_eq("byte_lane", rdata_s[1], 32'hDEAD_BEAA);
    run_txn(1, 0, 1, 32'h10, 32'h5555_5555, 4'h0);
    run_txn(1, 1, 0, 32'h10, 32'h0, 4'h0);

    run_txn(0, 0, 1, 32'h20, 32'h1234_5678, 4'hF);
    run_txn(0, 1, 0, 32'h20, 32'h0, 4'h0);
    check_eq("b2b_raw", rdata_s[0], 32'h1234_5678);

    run_txn(0, 0, 1, 32'h30, 32'hA5A5_0001, 4'hF);
    run_txn(0, 1, 1, 32'h30, 32'hFFFF_FFFF, 4'hF);
    run_txn(0, 1, 0, 32'h30, 32'h0, 4'h0);

    run_txn(1, 1, 0, 32'h12, 32'h0, 4'h0);
    run_txn(1, 0, 1, 32'h0, 32'h0BAD_F00D, 4'hF);
    run_txn(1, 0, 1, 32'h1000, 32'h600D_CAFE, 4'hF);
    run_txn(1, 1, 0, 32'h0, 32'h0, 4'h0);

    run_txn(2, 0, 1, 32'h40, 32'hCAFE_F00D, 4'hF);
    addr_s[2] = 32'h40; wdata_s[2] = 32'h1111_2222; be_s[2] = 4'hF; wr_s[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    for (int e = 0; e < 4; e++) begin
      check_eq("rst_hold_ready", {31'd0, rdy_s[2]}, 32'd0);
      @(posedge clk); #1;
    end
    wr_s[2] = 1'b0;
    reset = 1'b0;
    check_eq("post_rst_ready", {31'd0, rdy_s[2]}, 32'd0);
    check_eq("post_rst_rdata", rdata_s[2], 32'd0);
    for (int u = 0; u < 3; u++) begin
      rd_m[u] = '0; rd_ok[u] = 1'b1;
    end
    @(posedge clk); #1;
    run_txn(2, 1, 0, 32'h40, 32'h0, 4'h0);

    for (int u = 0; u < 3; u++) begin
      for (int t = 0; t < 30; t++) begin
        a = 32'($urandom_range(0, 15)) << 2;
        if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
        if ($urandom_range(0, 7) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
        k = $urandom_range(0, 9);
        run_txn(u, (k == 0) || (k < 5), (k == 0) || (k >= 5), a, $urandom, 4'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
